// File: rtl/tag_sysid_pkg.sv
// Shared register map, CONTROL/STATUS bit positions and the address width
// for the system-ID register block, plus a byte-lane merge helper.
package tag_sysid_pkg;

  localparam int ADDR_W = 4;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_ID     = 4'd0;
  localparam addr_t ADDR_TS     = 4'd1;
  localparam addr_t ADDR_UP_LO  = 4'd2;
  localparam addr_t ADDR_UP_HI  = 4'd3;
  localparam addr_t ADDR_CTRL   = 4'd4;
  localparam addr_t ADDR_STAT   = 4'd5;
  localparam addr_t ADDR_SCR0   = 4'd6;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;
  localparam int STAT_OVF_BIT = 0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tag_sysid_regs_if.sv
// Memory-mapped slave bus for the system-ID block: word address, read/write
// strobes with byte lanes, and pipelined readdata/readdatavalid return.
interface tag_sysid_regs_if;
  import tag_sysid_pkg::*;

  addr_t       address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/tag_sysid_rdpipe.sv
// Read-return delay line: READ_LATENCY register stages, one read per cycle, no stalls.
// Each stage only loads data alongside a valid, so the output holds its last value.
module tag_sysid_rdpipe #(
  parameter int READ_LATENCY = 1,
  parameter int WIDTH        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  logic [READ_LATENCY-1:0]            vld_q, vld_d;
  logic [READ_LATENCY-1:0][WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_vld;
    if (in_vld) dat_d[0] = in_dat;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  // Reset flushes in-flight reads so none return after reset releases.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[READ_LATENCY-1];
  assign out_dat = dat_q[READ_LATENCY-1];

endmodule

// File: rtl/tag_sysid_regs.sv
// System ID / build timestamp / 64-bit uptime register block with scratch registers.
// Reads return READ_LATENCY cycles after acceptance, fully pipelined; never stalls.
module tag_sysid_regs
  import tag_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h6070_2C69,
  parameter logic [31:0] TIMESTAMP    = 32'h0,
  parameter int          N_SCRATCH    = 2,
  parameter int          READ_LATENCY = 1
) (
  input logic             clock,
  input logic             reset_n,
  tag_sysid_regs_if.slave bus
);

  logic [63:0]                 cnt_q, cnt_d;
  logic [31:0]                 shadow_q, shadow_d;
  logic                        en_q, en_d;
  logic                        ovf_q, ovf_d;
  logic [N_SCRATCH-1:0][31:0]  scratch_q, scratch_d;

  logic        rd_acc;
  logic        wr_ctrl;
  logic        clr;
  logic        ovf_clr;
  logic        wrap;
  logic [31:0] rd_dat;

  // A write in the same cycle as a read takes priority; the read is dropped.
  assign rd_acc  = bus.read && !bus.write;
  assign wr_ctrl = bus.write && (bus.address == ADDR_CTRL) && bus.byteenable[0];
  assign clr     = wr_ctrl && bus.writedata[CTRL_CLR_BIT];
  assign ovf_clr = bus.write && (bus.address == ADDR_STAT) && bus.byteenable[0]
                   && bus.writedata[STAT_OVF_BIT];
  assign wrap    = en_q && (&cnt_q);

  always_comb begin
    rd_dat = '0;
    case (bus.address)
      ADDR_ID:    rd_dat = ID_VALUE;
      ADDR_TS:    rd_dat = TIMESTAMP;
      ADDR_UP_LO: rd_dat = cnt_q[31:0];
      ADDR_UP_HI: rd_dat = shadow_q;
      ADDR_CTRL:  rd_dat[CTRL_EN_BIT] = en_q;
      ADDR_STAT:  rd_dat[STAT_OVF_BIT] = ovf_q;
      default:    rd_dat = '0;
    endcase
    for (int i = 0; i < N_SCRATCH; i++) begin
      if (bus.address == ADDR_SCR0 + addr_t'(i)) rd_dat = scratch_q[i];
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    en_d      = en_q;
    ovf_d     = ovf_q;
    scratch_d = scratch_q;

    if (clr)       cnt_d = '0;
    else if (en_q) cnt_d = cnt_q + 64'd1;

    // Clear beats wrap; a wrap beats a coincident software OVF clear.
    if (wrap && !clr) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    if (wr_ctrl) en_d = bus.writedata[CTRL_EN_BIT];

    // Latching HI on the LO read makes a LO-then-HI pair coherent.
    if (rd_acc && (bus.address == ADDR_UP_LO)) shadow_d = cnt_q[63:32];

    for (int i = 0; i < N_SCRATCH; i++) begin
      if (bus.write && (bus.address == ADDR_SCR0 + addr_t'(i)))
        scratch_d[i] = merge_bytes(scratch_q[i], bus.writedata, bus.byteenable);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      en_q      <= 1'b1;
      ovf_q     <= 1'b0;
      scratch_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
      scratch_q <= scratch_d;
    end
  end

  tag_sysid_rdpipe #(
    .READ_LATENCY (READ_LATENCY),
    .WIDTH        (32)
  ) u_rdpipe (
    .clock   (clock),
    .reset_n (reset_n),
    .in_vld  (rd_acc),
    .in_dat  (rd_dat),
    .out_vld (bus.readdatavalid),
    .out_dat (bus.readdata)
  );

endmodule

// File: doc/tag_sysid_regs.md
TAG_SYSID_REGS -- requirements
Module: tag_sysid_regs

Interface
REQ-001 The parameters SHALL be, one per line, as follows:
- ID_VALUE, default 32'h6070_2C69, system ID word.
- TIMESTAMP, default 32'h0, build timestamp word.
- N_SCRATCH, default 2, range 1..4, number of scratch registers.
- READ_LATENCY, default 1, range 1..3, cycles from read accept to readdatavalid.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, named clock and reset_n.
REQ-003 The ports SHALL be, one per line, as follows:
- clock, input, 1, sole clock; all logic on its rising edge.
- reset_n, input, 1, synchronous active-low reset.
- address, input, 4, word address.
- read, input, 1, read request.
- write, input, 1, write request.
- writedata, input, 32, write data.
- byteenable, input, 4, byte lanes for writes.
- readdata, output, 32, registered read data.
- readdatavalid, output, 1, one-cycle pulse qualifying readdata.

Function
REQ-004 The register map SHALL be:
- 0: ID (RO, ID_VALUE).
- 1: TIMESTAMP (RO).
- 2: UPTIME_LO (RO).
- 3: UPTIME_HI shadow (RO).
- 4: CONTROL (bit0 EN RW; bit1 CLR write-1, self-clearing).
- 5: STATUS (bit0 OVF, write-1-to-clear).
- 6..6+N_SCRATCH-1: SCRATCH (RW).
REQ-005 Reads of unmapped addresses and of unused bits SHALL return 0, and writes to them SHALL be ignored.
REQ-006 Writes to RO registers SHALL be ignored.
REQ-007 The uptime counter SHALL be 64 bits and SHALL increment by 1 each cycle while EN=1.
REQ-008 On wrap from all-ones to 0, the counter SHALL set OVF.
REQ-009 A read of UPTIME_LO SHALL return the low 32 bits and, in the same cycle, copy the high 32 bits into the UPTIME_HI shadow, so that a LO-then-HI sequence is coherent.
REQ-010 A write of 1 to CLR SHALL zero the counter on the following cycle, regardless of EN.
REQ-011 CLR SHALL always read 0.
REQ-012 When CLR and counter wrap coincide, the clear SHALL win and OVF SHALL NOT be set.
REQ-013 On a write of 1 to STATUS bit0, OVF SHALL clear.
REQ-014 When an OVF clear and an OVF set coincide in the same cycle, the set SHALL win.
REQ-015 SCRATCH writes SHALL honour byteenable per byte lane; byteenable=0 SHALL leave the register unchanged.
REQ-016 Read data SHALL be sampled in the cycle read is asserted.
REQ-017 readdata and readdatavalid SHALL appear exactly READ_LATENCY cycles after the read is accepted.
REQ-018 The block SHALL accept one read per cycle with back-to-back reads fully pipelined and no stalls.
REQ-019 readdatavalid SHALL pulse once per accepted read.
REQ-020 readdata SHALL hold its last value when readdatavalid=0.
REQ-021 When read and write are asserted in the same cycle, the write SHALL be performed, the read SHALL be dropped, and no readdatavalid SHALL be produced.
REQ-022 A read in the cycle immediately after a write to the same address SHALL return the new value.
REQ-023 Write effects SHALL take place at the clock edge of the write cycle.

Reset
REQ-024 While reset_n=0 at a clock edge, the block SHALL hold the following values:
- Counter = 0.
- UPTIME_HI shadow = 0.
- EN = 1.
- OVF = 0.
- All SCRATCH = 0.
- readdata = 0.
- readdatavalid = 0.
REQ-025 Reads in flight in the latency pipeline when reset asserts SHALL be discarded and SHALL produce no readdatavalid after reset deasserts.
REQ-026 The counter SHALL begin incrementing on the first clock edge with reset_n=1.

Structure
REQ-027 Register offsets, CONTROL/STATUS bit positions and the 4-bit address width SHALL reside in shared package tag_sysid_pkg.
REQ-028 The read-latency delay line for data and valid SHALL be a sub-module tag_sysid_rdpipe, parametrised by READ_LATENCY and width.
REQ-029 The top level SHALL contain the register file, counter and decode.

Verification
REQ-030 Reset-then-read test: after reset, read addresses 0, 1 and 4 with READ_LATENCY=2 -> values 32'h6070_2C69, TIMESTAMP and 32'h1 returned, each 2 cycles after its read.
REQ-031 Back-to-back read test: issue 8 reads on consecutive cycles across addresses 0..7 -> 8 consecutive readdatavalid pulses, in order; unmapped addresses return 0.
REQ-032 Scratch byte-lane test: write 32'hDEAD_BEEF to SCRATCH0 with byteenable 4'b0101 from reset -> SCRATCH0 reads 32'h00AD_00EF; simultaneous read and write produces no readdatavalid.
REQ-033 Counter-wrap test: force the counter to 64'hFFFF_FFFF_FFFF_FFFE and run 2 cycles -> counter is 0 and OVF=1; write 1 to STATUS -> OVF=0; CLR coincident with wrap -> OVF stays 0.
REQ-034 Coherent-read test: with counter at 64'h0000_0001_FFFF_FFFF, read LO then HI over the following cycles -> LO=32'hFFFF_FFFF and HI=32'h1.
REQ-035 Reset-mid-flight test: pulse reset_n low for 1 cycle while 2 reads are in flight (READ_LATENCY=3) -> no readdatavalid after reset, and counter restarts from 0.
